// File: rtl/dr_pkg.sv
// Dual-rail codeword constants, responder state encoding and per-pair helper functions.
// Latency: none (definitions only).
// Backpressure: not applicable.
package dr_pkg;

    localparam logic [1:0] DR_NULL = 2'b00;
    localparam logic [1:0] DR_0    = 2'b01;
    localparam logic [1:0] DR_1    = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    function automatic logic dr_valid(input logic [1:0] p);
        return (p == DR_0) || (p == DR_1);
    endfunction

    function automatic logic dr_null(input logic [1:0] p);
        return p == DR_NULL;
    endfunction

    function automatic logic dr_decode(input logic [1:0] p);
        return p == DR_1;
    endfunction

    function automatic logic [1:0] dr_encode(input logic b);
        return b ? DR_1 : DR_0;
    endfunction

endpackage

// File: rtl/dr_mem_responder_if.sv
// Dual-rail memory request/response channel between the async core and the responder.
// Latency: none (wiring only).
// Backpressure: 4-phase return-to-zero handshakes on ack_req and ack_rdata.
interface dr_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [2*ADDR_W-1:0] addr_dr;
    logic [1:0]          rw_dr;
    logic [2*DATA_W-1:0] wdata_dr;
    logic                ack_req;
    logic [2*DATA_W-1:0] rdata_dr;
    logic                ack_rdata;

    modport master (output addr_dr, rw_dr, wdata_dr, ack_rdata, input ack_req, rdata_dr);
    modport slave  (input addr_dr, rw_dr, wdata_dr, ack_rdata, output ack_req, rdata_dr);
endinterface

// File: rtl/dr_sync.sv
// Multi-flop synchronizer for asynchronous inputs, cleared to 0 on reset.
// Latency: STAGES clock edges.
// Backpressure: none; samples every cycle.
module dr_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg <= '0;
        else        stg <= {stg[STAGES-2:0], d};
    end

    assign q = stg[STAGES-1];
endmodule

// File: rtl/dr_mem_responder.sv
// Clocked responder turning 4-phase dual-rail requests into RAM accesses; optional DR_ILLEGAL_DET_EN adds err.
// Latency: SYNC_STAGES+3 edges from stable request to ack_req; read token issued with ack_req.
// Backpressure: next request waits until request RTZ and read-token RTZ both complete.
module dr_mem_responder
    import dr_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dr_mem_responder_if.slave    bus
`ifdef DR_ILLEGAL_DET_EN
    ,
    output logic                 err
`endif
);
    localparam int REQ_W = 2*ADDR_W + 2 + 2*DATA_W;

    logic [REQ_W-1:0]    s_req, prev_req, cap_req;
    logic                s_ack;
    state_t              state_q, state_nx;

    logic                req_complete, req_null, req_ill, capture;
    logic                cap_read;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata, rd_reg, rd_word;
    logic [2*DATA_W-1:0] rd_enc;
    logic                req_done, rd_done, rd_sent, rd_acked;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    dr_sync #(.WIDTH(REQ_W), .STAGES(SYNC_STAGES)) u_sync_req (
        .clk(clk), .rst_n(rst_n), .d({bus.addr_dr, bus.rw_dr, bus.wdata_dr}), .q(s_req));
    dr_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_ack (
        .clk(clk), .rst_n(rst_n), .d(bus.ack_rdata), .q(s_ack));

    // Request bus layout: {addr pairs, rw pair, wdata pairs}, wdata at the bottom.
    always_comb begin
        logic addr_ok, wd_ok, rw_ok;
        addr_ok = 1'b1;
        wd_ok   = 1'b1;
        req_ill = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            wd_ok   &= dr_valid(s_req[2*i +: 2]);
            req_ill |= (s_req[2*i +: 2] == DR_ILL);
        end
        for (int i = 0; i < ADDR_W; i++) begin
            addr_ok &= dr_valid(s_req[2*DATA_W + 2 + 2*i +: 2]);
            req_ill |= (s_req[2*DATA_W + 2 + 2*i +: 2] == DR_ILL);
        end
        rw_ok   = dr_valid(s_req[2*DATA_W +: 2]);
        req_ill |= (s_req[2*DATA_W +: 2] == DR_ILL);
        req_complete = rw_ok && addr_ok && (dr_decode(s_req[2*DATA_W +: 2]) || wd_ok);
        req_null     = (s_req == '0);
        capture      = (state_q == IDLE) && req_complete && (s_req == prev_req);
    end

    always_comb begin
        cap_read = dr_decode(cap_req[2*DATA_W +: 2]);
        cap_addr = '0;
        cap_wdata = '0;
        for (int i = 0; i < ADDR_W; i++) cap_addr[i] = dr_decode(cap_req[2*DATA_W + 2 + 2*i +: 2]);
        for (int i = 0; i < DATA_W; i++) cap_wdata[i] = dr_decode(cap_req[2*i +: 2]);
        rd_word = (state_q == ACCESS) ? mem[cap_addr] : rd_reg;
        rd_enc  = '0;
        for (int i = 0; i < DATA_W; i++) rd_enc[2*i +: 2] = dr_encode(rd_word[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE:    if (capture) state_nx = ACCESS;
            ACCESS:  state_nx = HOLD;
            HOLD:    if (req_done && rd_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_q == ACCESS) begin
            if (cap_read) rd_reg <= mem[cap_addr];
            else          mem[cap_addr] <= cap_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ack_req  <= 1'b0;
            bus.rdata_dr <= '0;
            prev_req     <= '0;
            cap_req      <= '0;
            req_done     <= 1'b0;
            rd_done      <= 1'b0;
            rd_sent      <= 1'b0;
            rd_acked     <= 1'b0;
        end else begin
            prev_req <= s_req;
            case (state_q)
                IDLE: if (capture) begin
                    cap_req  <= s_req;
                    req_done <= 1'b0;
                    rd_done  <= 1'b0;
                    rd_sent  <= 1'b0;
                    rd_acked <= 1'b0;
                end
                ACCESS: begin
                    bus.ack_req <= 1'b1;
                    if (!cap_read) begin
                        rd_done <= 1'b1;
                    end else if (!s_ack) begin
                        bus.rdata_dr <= rd_enc;
                        rd_sent      <= 1'b1;
                    end
                end
                HOLD: begin
                    if (req_null) begin
                        bus.ack_req <= 1'b0;
                        req_done    <= 1'b1;
                    end
                    // Token is withheld while a stale ack_rdata is still high.
                    if (cap_read && !rd_done) begin
                        if (!rd_sent) begin
                            if (!s_ack) begin
                                bus.rdata_dr <= rd_enc;
                                rd_sent      <= 1'b1;
                            end
                        end else if (!rd_acked) begin
                            if (s_ack) begin
                                bus.rdata_dr <= '0;
                                rd_acked     <= 1'b1;
                            end
                        end else if (!s_ack) begin
                            rd_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DR_ILLEGAL_DET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      err <= 1'b0;
        else if (req_ill && (state_q != ACCESS))         err <= 1'b1;
    end
`else
    logic unused_ill;
    assign unused_ill = req_ill;
`endif
endmodule

// File: tb/tb_dr_mem_responder.sv
// Directed self-checking bench for dr_mem_responder: vector table plus multi-cycle corner sequences.
module tb_dr_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dr_mem_responder_if bus ();
`ifdef DR_ILLEGAL_DET_EN
    logic err;
`endif

    dr_mem_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef DR_ILLEGAL_DET_EN
        ,
        .err(err)
`endif
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          rd;
        logic [7:0]  a;
        logic [15:0] d;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc16(input logic [15:0] v);
        logic [31:0] r;
        for (int i = 0; i < 16; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic logic [15:0] enc8(input logic [7:0] v);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic drive_req(input bit rd, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.addr_dr  = enc8(a);
        bus.rw_dr    = rd ? 2'b10 : 2'b01;
        bus.wdata_dr = rd ? 32'h0 : enc16(d);
    endtask

    task automatic drive_null();
        @(negedge clk);
        bus.addr_dr  = '0;
        bus.rw_dr    = '0;
        bus.wdata_dr = '0;
    endtask

    // Counts rising edges until ack_req is seen high; 30 means it never rose.
    task automatic wait_ack_rise(output int n);
        n = 0;
        while (n < 30) begin
            @(posedge clk); #1;
            n++;
            if (bus.ack_req) break;
        end
    endtask

    task automatic wait_ack_fall();
        for (int i = 0; i < 30 && bus.ack_req; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_txn(input bit rd, input logic [7:0] a, input logic [15:0] d);
        int n;
        drive_req(rd, a, d);
        wait_ack_rise(n);
        check(rd ? "rd_latency" : "wr_latency", 64'(n), 64'd5);
        if (rd) check("rd_token", 64'(bus.rdata_dr), 64'(enc16(d)));
        else    check("wr_rdata_null", 64'(bus.rdata_dr), 64'd0);
        drive_null();
        wait_ack_fall();
        check("ack_req_rtz", 64'(bus.ack_req), 64'd0);
        if (rd) begin
            @(negedge clk);
            bus.ack_rdata = 1'b1;
            for (int i = 0; i < 30 && bus.rdata_dr != 0; i++) begin
                @(posedge clk); #1;
            end
            check("rdata_rtz", 64'(bus.rdata_dr), 64'd0);
            @(negedge clk);
            bus.ack_rdata = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        int n;
        int seen;

        vecs[0]  = '{0, 8'h3C, 16'hBEEF};
        vecs[1]  = '{1, 8'h3C, 16'hBEEF};
        vecs[2]  = '{0, 8'h00, 16'h0000};
        vecs[3]  = '{0, 8'hFF, 16'hFFFF};
        vecs[4]  = '{1, 8'h00, 16'h0000};
        vecs[5]  = '{1, 8'hFF, 16'hFFFF};
        vecs[6]  = '{0, 8'h00, 16'hFFFF};
        vecs[7]  = '{1, 8'hFF, 16'hFFFF};
        vecs[8]  = '{1, 8'h00, 16'hFFFF};
        vecs[9]  = '{0, 8'hFF, 16'h0000};
        vecs[10] = '{1, 8'h00, 16'hFFFF};
        vecs[11] = '{1, 8'hFF, 16'h0000};

        rst_n = 1'b0;
        bus.addr_dr = '0;
        bus.rw_dr = '0;
        bus.wdata_dr = '0;
        bus.ack_rdata = 1'b0;
        #1;
        check("reset_ack_req", 64'(bus.ack_req), 64'd0);
        check("reset_rdata", 64'(bus.rdata_dr), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ack_req", 64'(bus.ack_req), 64'd0);

        for (int i = 0; i < 12; i++) do_txn(vecs[i].rd, vecs[i].a, vecs[i].d);

        // Held ack_rdata blocks the next capture even after the request has returned to NULL.
        drive_req(1, 8'h3C, 16'h0);
        wait_ack_rise(n);
        check("hold_rd_latency", 64'(n), 64'd5);
        check("hold_rd_token", 64'(bus.rdata_dr), 64'(enc16(16'hBEEF)));
        @(negedge clk);
        bus.ack_rdata = 1'b1;
        drive_null();
        repeat (10) @(negedge clk);
        check("hold_ack_rtz", 64'(bus.ack_req), 64'd0);
        check("hold_rdata_rtz", 64'(bus.rdata_dr), 64'd0);
        drive_req(0, 8'h10, 16'h1234);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.ack_req) seen++;
        end
        check("no_capture_while_ack_rdata", 64'(seen), 64'd0);
        @(negedge clk);
        bus.ack_rdata = 1'b0;
        wait_ack_rise(n);
        check("capture_after_ack_rdata_low", 64'(n), 64'd6);
        drive_null();
        wait_ack_fall();
        repeat (6) @(negedge clk);
        do_txn(1, 8'h10, 16'h1234);

        // Skewed address arrival: two pairs per cycle.
        @(negedge clk);
        bus.rw_dr = 2'b01;
        bus.wdata_dr = enc16(16'h5A5A);
        bus.addr_dr = '0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] full;
            if (k > 0) @(negedge clk);
            full = enc8(8'hA5);
            bus.addr_dr[4*k +: 4] = full[4*k +: 4];
            if (k < 3) begin
                @(posedge clk); #1;
                if (bus.ack_req) seen++;
            end
        end
        wait_ack_rise(n);
        check("skew_no_early_ack", 64'(seen), 64'd0);
        check("skew_latency", 64'(n), 64'd5);
        drive_null();
        wait_ack_fall();
        repeat (6) @(negedge clk);
        do_txn(1, 8'hA5, 16'h5A5A);

        // Reset during HOLD of a read.
        drive_req(1, 8'h3C, 16'h0);
        wait_ack_rise(n);
        check("rst_pre_token", 64'(bus.rdata_dr), 64'(enc16(16'hBEEF)));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack_req", 64'(bus.ack_req), 64'd0);
        check("rst_mid_rdata", 64'(bus.rdata_dr), 64'd0);
        drive_null();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_txn(1, 8'h3C, 16'hBEEF);

`ifdef DR_ILLEGAL_DET_EN
        check("err_clear", 64'(err), 64'd0);
        @(negedge clk);
        bus.addr_dr = enc8(8'h22);
        bus.rw_dr = 2'b11;
        bus.wdata_dr = enc16(16'hCAFE);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.ack_req) seen++;
        end
        check("ill_err_set", 64'(err), 64'd1);
        check("ill_no_ack", 64'(seen), 64'd0);
        drive_null();
        repeat (4) @(negedge clk);
        do_txn(0, 8'h22, 16'hCAFE);
        do_txn(1, 8'h22, 16'hCAFE);
        check("ill_err_sticky", 64'(err), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("ill_err_reset", 64'(err), 64'd0);
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
